axis_baser_tx_arb: RTL

Frame-level arbiter sharing one 64-bit AXI4-Stream transmit path, i.e. the frame input of the 10GBASE-R transmitter, between up to `PORTS` frame sources. Grants the path to one source per frame, holds the grant until that frame's `tlast` beat is accepted, then re-arbitrates round-robin. Sits directly in front of the 10GBASE-R TX encoder. Frames are never interleaved, so the encoder sees whole frames only.

---
 rtl/axis_baser_tx_arb_if.sv | 23 ++
 rtl/axis_baser_tx_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axis_baser_tx_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_baser_tx_arb_if
// Brief    : N-lane AXI4-Stream bundle (lane i at [i*width +: width]).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_baser_tx_arb_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input  tready);
    modport slave  (input  tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_baser_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_baser_tx_arb
// Brief    : Frame-level round-robin arbiter in front of the 10GBASE-R TX
//            encoder. Define AXIS_TX_ARB_STRICT_PRIO_EN for strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module axis_baser_tx_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PORTS      = 4,
    parameter int SEL_WIDTH  = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_baser_tx_arb_if.slave    s_axis,
    axis_baser_tx_arb_if.master   m_axis,
    output logic                  grant_valid,
    output logic [SEL_WIDTH-1:0]  grant_index,
    output logic                  frame_done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   grant_q, grant_d;
    logic [SEL_WIDTH-1:0]   winner;
    logic                   found;
    logic [PORTS-1:0]       tready;
    logic                   accept;

    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [KEEP_WIDTH-1:0]  out_keep_q;
    logic                   out_last_q;
    logic                   out_user_q;

`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
    localparam logic [SEL_WIDTH-1:0] RR_RESET = SEL_WIDTH'(PORTS - 1);
    logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]   rr_idx;
`endif

    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef AXIS_TX_ARB_STRICT_PRIO_EN
        for (int i = 0; i < PORTS; i++) begin
            if (!found && s_axis.tvalid[i]) begin
                winner = SEL_WIDTH'(i);
                found  = 1'b1;
            end
        end
`else
        rr_idx = '0;
        // Search starts one past the last granted source and wraps onto it.
        for (int i = 1; i <= PORTS; i++) begin
            rr_idx = SEL_WIDTH'((int'(rr_ptr_q) + i) % PORTS);
            if (!found && s_axis.tvalid[rr_idx]) begin
                winner = rr_idx;
                found  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tready     = '0;
        accept     = 1'b0;
        frame_done = 1'b0;
`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = ST_XFER;
`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
                    rr_ptr_d = winner;
`endif
                end
            end
            ST_XFER: begin
                tready[grant_q] = !out_valid_q || m_axis.tready[0];
                accept          = tready[grant_q] && s_axis.tvalid[grant_q];
                if (accept && s_axis.tlast[grant_q]) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
            rr_ptr_q <= RR_RESET;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Single output register; a load in the same cycle as a drain keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= s_axis.tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            out_keep_q  <= s_axis.tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
            out_last_q  <= s_axis.tlast[grant_q];
            out_user_q  <= s_axis.tuser[grant_q];
        end else if (m_axis.tready[0]) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
        end
    end

    assign s_axis.tready = tready;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = out_keep_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tuser  = out_user_q;
    assign grant_valid   = (state_q == ST_XFER);
    assign grant_index   = grant_q;

endmodule
`default_nettype wire
